// File: rtl/ap_ctrl_profiler.sv
`timescale 1ns/1ps
// ap_ctrl_profiler: synthesizable per-channel HLS block-level handshake profiler.
// Follows ap_start/ap_done/ap_continue of NUM_CH sub-modules. Keeps saturating
// transaction, busy, continue-stall and ready counters per channel, plus the
// min/max latency. All results come out through a registered read port.
// Optional feature: define AP_CTRL_PROFILER_HIST_EN to add an 8-bin log2 latency
// histogram per channel. The bins are read at rd_sel 8..15.
module ap_ctrl_profiler #(
  parameter int NUM_CH = 16,
  parameter int CNT_W  = 32,
  parameter int LAT_W  = 24,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [NUM_CH-1:0] ch_start,
  input  logic [NUM_CH-1:0] ch_ready,
  input  logic [NUM_CH-1:0] ch_done,
  input  logic [NUM_CH-1:0] ch_continue,
  input  logic              prof_en,
  input  logic              finish,
  input  logic              clear,
  input  logic              rd_req,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [3:0]        rd_sel,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic              frozen
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    DONE_WAIT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [LAT_W-1:0] LAT_MAX = '1;

  state_t           state        [NUM_CH];
  logic [LAT_W-1:0] lat_cnt      [NUM_CH];
  logic [LAT_W-1:0] lat_min      [NUM_CH];
  logic [LAT_W-1:0] lat_max      [NUM_CH];
  logic [CNT_W-1:0] txn_count    [NUM_CH];
  logic [CNT_W-1:0] busy_cycles  [NUM_CH];
  logic [CNT_W-1:0] stall_cycles [NUM_CH];
  logic [CNT_W-1:0] ready_count  [NUM_CH];
  logic [LAT_W-1:0] done_lat     [NUM_CH];
  logic [NUM_CH-1:0] record;
  logic [NUM_CH-1:0] sat;
  logic [CNT_W-1:0] rd_word;
  logic             active;
`ifdef AP_CTRL_PROFILER_HIST_EN
  logic [CNT_W-1:0] hist    [NUM_CH][8];
  logic [2:0]       lat_bin [NUM_CH];
`endif

  assign active = prof_en && !frozen;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [LAT_W-1:0] lat_inc(input logic [LAT_W-1:0] v);
    return (v == LAT_MAX) ? v : v + LAT_W'(1);
  endfunction

`ifdef AP_CTRL_PROFILER_HIST_EN
  function automatic logic [2:0] bin_of(input logic [LAT_W-1:0] l);
    logic [2:0] b;
    b = 3'd7;
    if (32'(l) < 32'd128) begin
      b = 3'd0;
      for (int k = 1; k < 7; k++) begin
        if (32'(l) >= (32'd1 << k)) b = 3'(k);
      end
    end
    return b;
  endfunction
`endif

  // Latency of a transaction that finishes this cycle, whether it is recorded, and the sticky saturation flag
  always_comb begin
    record = '0;
    sat    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      done_lat[i] = (state[i] == IDLE) ? LAT_W'(1) : lat_inc(lat_cnt[i]);
      record[i]   = ch_done[i] && ((state[i] == BUSY) || ((state[i] == IDLE) && ch_start[i]));
      // Counters only climb until they are cleared, so a pinned counter already acts as a sticky flag
      sat[i] = (txn_count[i] == CNT_MAX) || (busy_cycles[i] == CNT_MAX) ||
               (stall_cycles[i] == CNT_MAX) || (ready_count[i] == CNT_MAX);
`ifdef AP_CTRL_PROFILER_HIST_EN
      lat_bin[i] = bin_of(done_lat[i]);
      for (int k = 0; k < 8; k++) begin
        if (hist[i][k] == CNT_MAX) sat[i] = 1'b1;
      end
`endif
    end
  end

  // Per-channel handshake FSMs and counters; clear wins over finish and counting
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      frozen <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        state[i]        <= IDLE;
        lat_cnt[i]      <= '0;
        lat_min[i]      <= LAT_MAX;
        lat_max[i]      <= '0;
        txn_count[i]    <= '0;
        busy_cycles[i]  <= '0;
        stall_cycles[i] <= '0;
        ready_count[i]  <= '0;
`ifdef AP_CTRL_PROFILER_HIST_EN
        for (int k = 0; k < 8; k++) hist[i][k] <= '0;
`endif
      end
    end else if (clear) begin
      frozen <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        state[i]        <= IDLE;
        lat_cnt[i]      <= '0;
        lat_min[i]      <= LAT_MAX;
        lat_max[i]      <= '0;
        txn_count[i]    <= '0;
        busy_cycles[i]  <= '0;
        stall_cycles[i] <= '0;
        ready_count[i]  <= '0;
`ifdef AP_CTRL_PROFILER_HIST_EN
        for (int k = 0; k < 8; k++) hist[i][k] <= '0;
`endif
      end
    end else begin
      if (finish) frozen <= 1'b1;
      if (active) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_ready[i]) ready_count[i] <= cnt_inc(ready_count[i]);
          if (record[i]) begin
            if (done_lat[i] < lat_min[i]) lat_min[i] <= done_lat[i];
            if (done_lat[i] > lat_max[i]) lat_max[i] <= done_lat[i];
`ifdef AP_CTRL_PROFILER_HIST_EN
            hist[i][lat_bin[i]] <= cnt_inc(hist[i][lat_bin[i]]);
`endif
          end
          case (state[i])
            IDLE: begin
              if (ch_start[i]) begin
                lat_cnt[i] <= LAT_W'(1);
                if (!ch_done[i]) begin
                  state[i] <= BUSY;
                end else if (ch_continue[i]) begin
                  txn_count[i] <= cnt_inc(txn_count[i]);
                  state[i]     <= BUSY;
                end else begin
                  state[i] <= DONE_WAIT;
                end
              end
            end
            BUSY: begin
              busy_cycles[i] <= cnt_inc(busy_cycles[i]);
              lat_cnt[i]     <= lat_inc(lat_cnt[i]);
              if (ch_done[i]) begin
                if (ch_continue[i]) begin
                  txn_count[i] <= cnt_inc(txn_count[i]);
                  if (ch_start[i]) begin
                    state[i]   <= BUSY;
                    lat_cnt[i] <= LAT_W'(1);
                  end else begin
                    state[i] <= IDLE;
                  end
                end else begin
                  state[i] <= DONE_WAIT;
                end
              end
            end
            DONE_WAIT: begin
              stall_cycles[i] <= cnt_inc(stall_cycles[i]);
              if (ch_continue[i]) begin
                txn_count[i] <= cnt_inc(txn_count[i]);
                if (ch_start[i]) begin
                  state[i]   <= BUSY;
                  lat_cnt[i] <= LAT_W'(1);
                end else begin
                  state[i] <= IDLE;
                end
              end
            end
            default: state[i] <= IDLE;
          endcase
        end
      end
    end
  end

  // Read-port field select over the pre-update counter values
  always_comb begin
    rd_word = '0;
    if (32'(rd_ch) < NUM_CH) begin
      case (rd_sel)
        4'd0: rd_word = txn_count[rd_ch];
        4'd1: rd_word = busy_cycles[rd_ch];
        4'd2: rd_word = stall_cycles[rd_ch];
        4'd3: rd_word = ready_count[rd_ch];
        4'd4: rd_word = CNT_W'(lat_min[rd_ch]);
        4'd5: rd_word = CNT_W'(lat_max[rd_ch]);
        4'd6: rd_word = CNT_W'({sat[rd_ch], state[rd_ch]});
        default: begin
`ifdef AP_CTRL_PROFILER_HIST_EN
          if (rd_sel[3]) rd_word = hist[rd_ch][rd_sel[2:0]];
`endif
        end
      endcase
    end
  end

  // Registered read response: one-cycle valid pulse per request
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_data <= rd_word;
    end
  end

endmodule

// File: tb/tb_ap_ctrl_profiler.sv
`timescale 1ns/1ps
// tb_ap_ctrl_profiler: scoreboard bench for ap_ctrl_profiler.
// A cycle-stamp reference model predicts every read response; a monitor pops and compares.
module tb_ap_ctrl_profiler;
  localparam int NUM_CH = 6;
  localparam int CNT_W  = 8;
  localparam int LAT_W  = 8;
  localparam int CH_W   = 3;
  localparam int CMAX   = (1 << CNT_W) - 1;
  localparam int LMAX   = (1 << LAT_W) - 1;

  typedef struct {
    int ch;
    int sel;
    int val;
  } rd_exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [NUM_CH-1:0] ch_start = '0;
  logic [NUM_CH-1:0] ch_ready = '0;
  logic [NUM_CH-1:0] ch_done = '0;
  logic [NUM_CH-1:0] ch_continue = '1;
  logic              prof_en = 1'b0;
  logic              finish = 1'b0;
  logic              clear = 1'b0;
  logic              rd_req = 1'b0;
  logic [CH_W-1:0]   rd_ch = '0;
  logic [3:0]        rd_sel = '0;
  logic              rd_valid;
  logic [CNT_W-1:0]  rd_data;
  logic              frozen;

  int checks = 0;
  int errors = 0;
  rd_exp_t exp_q[$];

  // reference model state: phases 0=idle, 1=busy, 2=waiting for continue
  int m_txn   [NUM_CH];
  int m_busy  [NUM_CH];
  int m_stall [NUM_CH];
  int m_ready [NUM_CH];
  int m_min   [NUM_CH];
  int m_max   [NUM_CH];
  int m_phase [NUM_CH];
  int m_begin [NUM_CH];
  int m_hist  [NUM_CH][8];
  bit m_frozen = 1'b0;
  int act = 0;

  ap_ctrl_profiler #(
    .NUM_CH(NUM_CH),
    .CNT_W(CNT_W),
    .LAT_W(LAT_W)
  ) dut (
    .ap_clk(clk),
    .ap_rst_n(rst_n),
    .ch_start(ch_start),
    .ch_ready(ch_ready),
    .ch_done(ch_done),
    .ch_continue(ch_continue),
    .prof_en(prof_en),
    .finish(finish),
    .clear(clear),
    .rd_req(rd_req),
    .rd_ch(rd_ch),
    .rd_sel(rd_sel),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .frozen(frozen)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int bump(input int v, input int lim);
    return (v >= lim) ? lim : v + 1;
  endfunction

  function automatic int lat_bin(input int l);
    int b = 0;
    if (l >= 128) return 7;
    while ((l >> (b + 1)) > 0) b++;
    return b;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NUM_CH; i++) begin
      m_txn[i] = 0; m_busy[i] = 0; m_stall[i] = 0; m_ready[i] = 0;
      m_min[i] = LMAX; m_max[i] = 0; m_phase[i] = 0; m_begin[i] = 0;
      for (int k = 0; k < 8; k++) m_hist[i][k] = 0;
    end
    m_frozen = 1'b0;
  endfunction

  function automatic int model_sat(input int ch);
    int s = 0;
    if (m_txn[ch] == CMAX || m_busy[ch] == CMAX || m_stall[ch] == CMAX || m_ready[ch] == CMAX) s = 1;
`ifdef AP_CTRL_PROFILER_HIST_EN
    for (int k = 0; k < 8; k++) if (m_hist[ch][k] == CMAX) s = 1;
`endif
    return s;
  endfunction

  function automatic int model_read(input int ch, input int sel);
    if (ch >= NUM_CH) return 0;
    case (sel)
      0: return m_txn[ch];
      1: return m_busy[ch];
      2: return m_stall[ch];
      3: return m_ready[ch];
      4: return m_min[ch];
      5: return m_max[ch];
      6: return model_sat(ch) * 4 + m_phase[ch];
      default: begin
`ifdef AP_CTRL_PROFILER_HIST_EN
        if (sel >= 8) return m_hist[ch][sel - 8];
`endif
        return 0;
      end
    endcase
  endfunction

  // a transaction ends now: latency is the number of enabled cycles since its start cycle, inclusive
  function automatic void model_record(input int i);
    int l = act - m_begin[i] + 1;
    if (l > LMAX) l = LMAX;
    if (l < m_min[i]) m_min[i] = l;
    if (l > m_max[i]) m_max[i] = l;
    m_hist[i][lat_bin(l)] = bump(m_hist[i][lat_bin(l)], CMAX);
  endfunction

  function automatic void model_release(input int i, input bit s);
    m_txn[i] = bump(m_txn[i], CMAX);
    m_phase[i] = s ? 1 : 0;
    m_begin[i] = act;
  endfunction

  function automatic void model_step(input int i, input bit s, input bit r, input bit d, input bit c);
    if (r) m_ready[i] = bump(m_ready[i], CMAX);
    case (m_phase[i])
      0: begin
        if (s) begin
          m_begin[i] = act;
          m_phase[i] = 1;
          if (d) begin
            model_record(i);
            if (c) model_release(i, s);
            else m_phase[i] = 2;
          end
        end
      end
      1: begin
        m_busy[i] = bump(m_busy[i], CMAX);
        if (d) begin
          model_record(i);
          if (c) model_release(i, s);
          else m_phase[i] = 2;
        end
      end
      default: begin
        m_stall[i] = bump(m_stall[i], CMAX);
        if (c) model_release(i, s);
      end
    endcase
  endfunction

  // model advances on every clock edge out of reset; reads capture pre-update values
  always @(posedge clk) begin : model_proc
    rd_exp_t e;
    if (rst_n) begin
      if (rd_req) begin
        e.ch = int'(rd_ch);
        e.sel = int'(rd_sel);
        e.val = model_read(int'(rd_ch), int'(rd_sel));
        exp_q.push_back(e);
      end
      if (clear) begin
        model_clear();
      end else begin
        if (prof_en && !m_frozen) begin
          for (int i = 0; i < NUM_CH; i++) model_step(i, ch_start[i], ch_ready[i], ch_done[i], ch_continue[i]);
          act++;
        end
        if (finish) m_frozen = 1'b1;
      end
    end
  end

  // monitor: every pushed expectation must be answered on the following cycle
  always @(negedge clk) begin : monitor_proc
    rd_exp_t m;
    if (rst_n) begin
      check_output("frozen", longint'(frozen), longint'(m_frozen));
      if (exp_q.size() > 0) begin
        m = exp_q.pop_front();
        if (rd_valid) begin
          check_output($sformatf("read ch%0d sel%0d", m.ch, m.sel), longint'(rd_data), longint'(m.val));
        end else begin
          check_output($sformatf("rd_valid for ch%0d sel%0d", m.ch, m.sel), 0, 1);
        end
      end else if (rd_valid) begin
        check_output("spurious rd_valid", 1, 0);
      end
    end
  end

  // start a new cycle with all single-cycle pulses dropped
  task automatic step();
    @(negedge clk);
    ch_start = '0; ch_ready = '0; ch_done = '0; ch_continue = '1;
    rd_req = 1'b0; finish = 1'b0; clear = 1'b0;
  endtask

  task automatic read_ch(input int ch);
    for (int s = 0; s < 16; s++) begin
      step();
      rd_req = 1'b1; rd_ch = CH_W'(ch); rd_sel = 4'(s);
    end
    step();
  endtask

  task automatic apply_stimulus(input int cycles, input bit with_clear);
    for (int n = 0; n < cycles; n++) begin
      step();
      prof_en     = ($urandom_range(9) != 0);
      ch_start    = NUM_CH'($urandom);
      ch_ready    = NUM_CH'($urandom);
      ch_done     = NUM_CH'($urandom & $urandom);
      ch_continue = NUM_CH'($urandom | $urandom);
      rd_req      = 1'($urandom_range(1));
      rd_ch       = CH_W'($urandom_range(7));
      rd_sel      = 4'($urandom);
      clear       = with_clear && ($urandom_range(299) == 0);
    end
    step();
    prof_en = 1'b1;
  endtask

  initial begin
    model_clear();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_output("reset rd_valid", longint'(rd_valid), 0);
    check_output("reset rd_data", longint'(rd_data), 0);
    check_output("reset frozen", longint'(frozen), 0);
    read_ch(0);
    prof_en = 1'b1;

    // ch0: start, three busy cycles, done with continue -> latency 5
    step(); ch_start[0] = 1'b1;
    repeat (3) step();
    step(); ch_done[0] = 1'b1;
    read_ch(0);

    // ch1: done with continue low for three stall cycles; txn read while stalled
    step(); ch_start[1] = 1'b1;
    step(); step();
    step(); ch_done[1] = 1'b1; ch_continue[1] = 1'b0;
    step(); ch_continue[1] = 1'b0; rd_req = 1'b1; rd_ch = 3'd1; rd_sel = 4'd0;
    step(); ch_continue[1] = 1'b0; rd_req = 1'b1; rd_ch = 3'd1; rd_sel = 4'd6;
    step();
    read_ch(1);

    // ch2: ready-only module pulsed seven times
    for (int n = 0; n < 7; n++) begin
      step(); ch_ready[2] = 1'b1;
      step();
    end
    read_ch(2);

    // ch3: chained transactions of latency 3 then 6
    step(); ch_start[3] = 1'b1;
    step();
    step(); ch_done[3] = 1'b1; ch_start[3] = 1'b1;
    repeat (4) step();
    step(); ch_done[3] = 1'b1;
    read_ch(3);

    // ch4: long busy period saturates busy_cycles and latency, then finish and clear
    step(); ch_start[4] = 1'b1;
    repeat (300) step();
    read_ch(4);
    step(); ch_done[4] = 1'b1;
    read_ch(4);
    step(); finish = 1'b1;
    for (int n = 0; n < 20; n++) begin
      step();
      ch_start = NUM_CH'($urandom); ch_ready = NUM_CH'($urandom); ch_done = NUM_CH'($urandom);
    end
    for (int c = 0; c < 8; c++) read_ch(c);
    step(); clear = 1'b1;
    for (int c = 0; c < 8; c++) read_ch(c);

    // randomized traffic with occasional clears and prof_en gaps
    apply_stimulus(2500, 1'b1);
    for (int c = 0; c < 8; c++) read_ch(c);

    // ch5: asynchronous reset in the middle of a transaction
    step(); ch_start[5] = 1'b1;
    step();
    step(); rd_req = 1'b1; rd_ch = 3'd5; rd_sel = 4'd1;
    @(posedge clk);
    #2;
    check_output("rd_valid before reset", longint'(rd_valid), 1);
    rst_n = 1'b0;
    model_clear();
    exp_q.delete();
    #1;
    check_output("async reset rd_valid", longint'(rd_valid), 0);
    check_output("async reset rd_data", longint'(rd_data), 0);
    check_output("async reset frozen", longint'(frozen), 0);
    @(negedge clk);
    rd_req = 1'b0; ch_start = '0;
    rst_n = 1'b1;
    read_ch(5);
    step(); step();

    check_output("pending reads", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ap_ctrl_profiler.md
Name: ap_ctrl_profiler

Overview:
- Synthesizable, parametrised successor to the testbench-only per-module status monitor.
- Watches ap_start/ap_ready/ap_done/ap_continue of NUM_CH HLS sub-modules (ap_ctrl_hs or ap_ctrl_chain).
- Per channel it tracks handshake state and accumulates transaction count, busy cycles, continue-stall cycles, ready-only pulses, and min/max latency.
- Results are read through a registered read port, so profiling works on hardware as well as in cosim.

Parameters:
- NUM_CH, 16, number of monitored channels (1..64).
- CNT_W, 32, width of the event/cycle counters; counters saturate.
- LAT_W, 24, width of the latency counter and the min/max registers.

Ports:
- ap_clk, in, 1, clock.
- ap_rst_n, in, 1, asynchronous active-low reset.
- ch_start, in, NUM_CH, per-channel ap_start (tie 0 for inline ready-only modules).
- ch_ready, in, NUM_CH, per-channel ap_ready.
- ch_done, in, NUM_CH, per-channel ap_done.
- ch_continue, in, NUM_CH, per-channel ap_continue (tie 1 for ap_ctrl_hs).
- prof_en, in, 1, profiling enable; when 0, all state and counters hold.
- finish, in, 1, run end; freezes all counters on the next edge (sticky).
- clear, in, 1, synchronous clear of counters, FSMs and the freeze flag.
- rd_req, in, 1, read request.
- rd_ch, in, $clog2(NUM_CH) (min 1), channel to read.
- rd_sel, in, 4, field select.
- rd_valid, out, 1, read data valid, one cycle after rd_req.
- rd_data, out, CNT_W, read data, zero-extended.
- frozen, out, 1, finish has been seen.

Behaviour:
- Reset (async, ap_rst_n=0): every FSM goes to IDLE; counters go to 0; lat_min goes to all-ones; lat_max to 0; rd_valid, rd_data and frozen to 0.
- Per-channel FSM (advances only when prof_en=1 and frozen=0):
  - IDLE -> BUSY on ch_start=1. lat_cnt is loaded with 1.
  - IDLE with ch_start=1 and ch_done=1 in the same cycle is a completed transaction of latency 1. Its next state follows the BUSY done rules.
  - BUSY: lat_cnt increments each cycle, saturating at all-ones. busy_cycles increments each cycle.
  - BUSY on ch_done=1:
    - Latch lat_cnt into lat_min/lat_max as needed.
    - If ch_continue=1: txn_count++. Next state is BUSY with lat_cnt=1 if ch_start=1, otherwise IDLE.
    - If ch_continue=0: next state is DONE_WAIT.
  - DONE_WAIT: stall_cycles increments each cycle. On ch_continue=1: txn_count++ and go to IDLE, or to BUSY with lat_cnt=1 if ch_start=1.
- ready_count increments on every ch_ready=1 cycle, independent of FSM state. This covers channels tied ch_start=0.
- All counters saturate at all-ones. A per-channel sticky sat flag is set when any of that channel's counters saturates.
- finish=1 sets frozen on the next edge. While frozen, nothing updates except reads.
- clear=1 restores all reset values on the next edge. clear takes priority over finish and over counting in the same cycle.
- Read port:
  - rd_req sampled at edge N gives rd_valid=1 at edge N+1, holding the data for rd_ch/rd_sel as of edge N (pre-update values).
  - rd_valid is a 1-cycle pulse; back-to-back reads every cycle are allowed.
  - rd_ch >= NUM_CH returns 0.
- rd_sel map:
  - 0: txn_count
  - 1: busy_cycles
  - 2: stall_cycles
  - 3: ready_count
  - 4: lat_min (all-ones if no transaction yet)
  - 5: lat_max
  - 6: status = {sat, state[1:0]}, state encoding IDLE=0, BUSY=1, DONE_WAIT=2
  - 7..15: 0, unless the optional feature is enabled.
- Reset asserted mid-transaction aborts it. The partial latency is not recorded.

Optional Feature:
- Macro AP_CTRL_PROFILER_HIST_EN.
- When defined: per channel, an 8-bin latency histogram of CNT_W-bit saturating counters.
  - Bin k counts latencies L with floor(log2 L) = k for k=0..6; bin 7 counts L >= 128.
  - A bin updates in the same cycle lat_min/lat_max update and is cleared with them.
  - rd_sel 8..15 read bins 0..7.
- When undefined: no histogram storage, and rd_sel 8..15 return 0.

Test Plan:
- ch0: start at cycle 10, done with continue=1 at cycle 14 -> txn_count=1, lat_min=lat_max=5, busy_cycles=4, ch0 returns to IDLE (status=0).
- ch1: done at cycle 20, continue held 0 until cycle 23 -> stall_cycles=3, txn_count=1 only after continue rises.
- ch2: start=0, ready pulsed 7 times -> ready_count=7, txn_count=0, lat_min=all-ones.
- ch3: done, continue and start together in BUSY, twice (latencies 3 and 6) -> txn_count=2, lat_min=3, lat_max=6; with AP_CTRL_PROFILER_HIST_EN, bin1=1 and bin2=1.
- CNT_W=4, ch4 held in BUSY 20 cycles -> busy_cycles=15, sat bit set; then finish -> frozen=1 and no further change; then clear -> all reset values.
- ap_rst_n dropped mid-BUSY on ch5 -> state IDLE, counters 0, rd_valid=0 immediately (async, no clock edge needed).
